pcie_axil_req_sequencer: RTL

- Upstream stage of the AXI-Lite master interface. Takes single-DW read/write requests decoded by the PCIe RX engine and sequences them one at a time onto the master's level-sensitive rd_en/wr_en interface.
- Read data, or a timeout error, is returned to the PCIe TX engine as a completion request. Writes are posted and produce no completion.
- Guarantees the enable low-gap the master needs to generate its rising-edge pulses.

---
 rtl/pcie_axil_pkg.sv | 19 +
 rtl/pcie_axil_req_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pcie_axil_pkg.sv
// Shared types and constants for the PCIe-to-AXI-Lite request path.
// Holds the sequencer state encoding, BAR-index field position and timeout fill word.
package pcie_axil_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_CPL  = 3'd2,
        WR_HOLD = 3'd3,
        GAP     = 3'd4
    } seq_state_e;

    // BAR index lives in the top two bits of the DW address
    localparam int BAR_IDX_MSB = 31;
    localparam int BAR_IDX_LSB = 30;

    localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/pcie_axil_req_sequencer.sv
// Sequences single-DW PCIe read/write requests one at a time onto the level-sensitive
// rd_en/wr_en master interface and returns read data (or a timeout) as a completion.
module pcie_axil_req_sequencer
    import pcie_axil_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned WR_HOLD_CYCLES = 4,
    parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT
) (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESETN,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_wr,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_data,
    input  logic [7:0]  req_tag,
    output logic [31:0] rd_addr,
    output logic [3:0]  rd_be,
    output logic        rd_en,
    input  logic [31:0] rd_data,
    input  logic        rd_data_valid,
    output logic [31:0] wr_addr,
    output logic [3:0]  wr_be,
    output logic [31:0] wr_data,
    output logic        wr_en,
    output logic        cpl_valid,
    input  logic        cpl_ready,
    output logic [7:0]  cpl_tag,
    output logic [31:0] cpl_data,
    output logic        cpl_err,
    output logic [7:0]  timeout_count,
    output logic        busy
);

    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(WR_HOLD_CYCLES - 1);

    seq_state_e  r_state;
    logic [15:0] r_timer;
    logic [7:0]  r_hold_cnt;
    logic [31:0] r_rd_addr;
    logic [3:0]  r_rd_be;
    logic        r_rd_en;
    logic [31:0] r_wr_addr;
    logic [3:0]  r_wr_be;
    logic [31:0] r_wr_data;
    logic        r_wr_en;
    logic        r_cpl_valid;
    logic [7:0]  r_cpl_tag;
    logic [31:0] r_cpl_data;
    logic        r_cpl_err;
    logic [7:0]  r_timeout_count;
    logic        r_busy;

    // Sequencer FSM: one transaction in flight, every output registered
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state         <= IDLE;
            r_timer         <= 16'd0;
            r_hold_cnt      <= 8'd0;
            r_rd_addr       <= 32'd0;
            r_rd_be         <= 4'd0;
            r_rd_en         <= 1'b0;
            r_wr_addr       <= 32'd0;
            r_wr_be         <= 4'd0;
            r_wr_data       <= 32'd0;
            r_wr_en         <= 1'b0;
            r_cpl_valid     <= 1'b0;
            r_cpl_tag       <= 8'd0;
            r_cpl_data      <= 32'd0;
            r_cpl_err       <= 1'b0;
            r_timeout_count <= 8'd0;
            r_busy          <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_busy <= 1'b1;
                        if (req_is_wr) begin
                            r_wr_addr  <= req_addr;
                            r_wr_be    <= req_be;
                            r_wr_data  <= req_data;
                            r_wr_en    <= 1'b1;
                            r_hold_cnt <= 8'd0;
                            r_state    <= WR_HOLD;
                        end else begin
                            r_rd_addr <= req_addr;
                            r_rd_be   <= req_be;
                            r_cpl_tag <= req_tag;
                            r_rd_en   <= 1'b1;
                            r_timer   <= 16'd0;
                            r_state   <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    // a response on the expiry cycle still wins over the timeout
                    if (rd_data_valid) begin
                        r_cpl_data  <= rd_data;
                        r_cpl_err   <= 1'b0;
                        r_cpl_valid <= 1'b1;
                        r_rd_en     <= 1'b0;
                        r_state     <= RD_CPL;
                    end else if (r_timer == TMO_LAST) begin
                        r_cpl_data  <= TIMEOUT_DATA;
                        r_cpl_err   <= 1'b1;
                        r_cpl_valid <= 1'b1;
                        r_rd_en     <= 1'b0;
                        if (r_timeout_count != 8'hFF) begin
                            r_timeout_count <= r_timeout_count + 8'd1;
                        end
                        r_state     <= RD_CPL;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                RD_CPL: begin
                    if (cpl_ready) begin
                        r_cpl_valid <= 1'b0;
                        r_state     <= GAP;
                    end
                end
                WR_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_wr_en <= 1'b0;
                        r_state <= GAP;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                GAP: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_rd_en     <= 1'b0;
                    r_wr_en     <= 1'b0;
                    r_cpl_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready     = (r_state == IDLE);
    assign rd_addr       = r_rd_addr;
    assign rd_be         = r_rd_be;
    assign rd_en         = r_rd_en;
    assign wr_addr       = r_wr_addr;
    assign wr_be         = r_wr_be;
    assign wr_data       = r_wr_data;
    assign wr_en         = r_wr_en;
    assign cpl_valid     = r_cpl_valid;
    assign cpl_tag       = r_cpl_tag;
    assign cpl_data      = r_cpl_data;
    assign cpl_err       = r_cpl_err;
    assign timeout_count = r_timeout_count;
    assign busy          = r_busy;

endmodule
